// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the clock divider controller.
// Holds the controller state encoding and the default divide-ratio width.
package clk_ctrl_pkg;

    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // RUN and DRAIN both drive the divided clock; only IDLE is quiet.
    function automatic logic is_active(input state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divide-by-2*(ratio+1) engine: phase counter, terminal-count detect and
// the registered divided clock. Clears to a quiet low output when not run.
module clk_div_core
    import clk_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             run,
    input  logic [CNT_W-1:0] ratio,
    output logic             tc,
    output logic             div_clk
);

    logic [CNT_W-1:0] cnt;

    // The counter never passes ratio, so an all-ones ratio cannot overflow.
    assign tc = run && (cnt == ratio);

    always_ff @(posedge clk or negedge clr_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (!clr_n) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (tc) begin
            cnt     <= '0;
            div_clk <= ~div_clk;
        end else begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: run/stop FSM with glitch-free draining and a
// req/ack handshake that swaps the divide ratio only on phase boundaries.
module clk_div_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RESET_DIV = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_busy,
    output logic             div_clk,
    output logic             tick,
    output logic             running
);

    localparam logic [CNT_W-1:0] RESET_RATIO = CNT_W'(RESET_DIV);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] ratio;
    logic [CNT_W-1:0] pending;
    logic             core_run;
    logic             tc;
    logic             accept;
    logic             apply;

    // Stopping from a low phase ends at once; a high phase must run to its TC.
    assign core_run = (state == ST_DRAIN) || ((state == ST_RUN) && (en || div_clk));

    clk_div_core #(
        .CNT_W   (CNT_W)
    ) u_core (
        .clk     (clk),
        .clr_n   (clr_n),
        .run     (core_run),
        .ratio   (ratio),
        .tc      (tc),
        .div_clk (div_clk)
    );

    assign tick    = tc;
    assign running = is_active(state);

    // A request is taken once per ack, and never while a ratio is still pending.
    assign accept = div_req && !div_busy && !div_ack;
    // Pending ratios land on a phase boundary, or at once if the divider stopped.
    assign apply  = div_busy && (tc || (state == ST_IDLE));

    always_comb begin
        // NOTE: assign the default first so every path drives state_nxt and
        // no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A high phase ending this cycle falls now, so there is nothing to drain.
                if (!en) state_nxt = (div_clk && !tc) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (en)      state_nxt = ST_RUN;
                else if (tc) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ratio    <= RESET_RATIO;
            pending  <= '0;
            div_busy <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            div_ack <= accept;
            if (accept) begin
                pending <= div_val;
                if (state == ST_IDLE) ratio    <= div_val;
                else                  div_busy <= 1'b1;
            end else if (apply) begin
                ratio    <= pending;
                div_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic,
// compared each cycle against a phase-based behavioural model.
module tb_clk_div_ctrl;

    localparam int CNT_W     = 4;
    localparam int RESET_DIV = 0;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             en;
    logic             div_req;
    logic [CNT_W-1:0] div_val;
    logic             div_ack;
    logic             div_busy;
    logic             div_clk;
    logic             tick;
    logic             running;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 stopped, 1 running, 2 finishing a high phase.
    int m_mode;
    int m_rem;      // cycles left in the current phase, this one included
    int m_ratio;
    int m_pend;
    bit m_clk;
    bit m_busy;
    bit m_ack;

    // Measured phase lengths of the DUT's divided clock.
    bit last_clk;
    int phase_cnt;
    int phases[$];

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .CNT_W     (CNT_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (en),
        .div_req  (div_req),
        .div_val  (div_val),
        .div_ack  (div_ack),
        .div_busy (div_busy),
        .div_clk  (div_clk),
        .tick     (tick),
        .running  (running)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s wait expired", tag);
    endtask

    function automatic void model_reset();
        m_mode  = 0;
        m_ratio = RESET_DIV;
        m_pend  = 0;
        m_busy  = 1'b0;
        m_ack   = 1'b0;
        m_clk   = 1'b0;
        m_rem   = RESET_DIV + 1;
    endfunction

    function automatic bit model_active();
        return (m_mode == 2) || ((m_mode == 1) && (en || m_clk));
    endfunction

    function automatic bit model_tc();
        return model_active() && (m_rem == 1);
    endfunction

    // One clock cycle: check outputs mid-cycle, then advance the model at posedge.
    task automatic cyc();
        bit active, tc_now, idle, acc;
        int ratio_n, mode_n, rem_n;
        bit clk_n, busy_n;
        #1;
        idle   = (m_mode == 0);
        active = model_active();
        tc_now = model_tc();
        check("div_clk",  32'(div_clk),  32'(m_clk));
        check("tick",     32'(tick),     32'(tc_now));
        check("running",  32'(running),  32'(!idle));
        check("div_ack",  32'(div_ack),  32'(m_ack));
        check("div_busy", 32'(div_busy), 32'(m_busy));

        if (div_clk !== last_clk) begin
            phases.push_back(phase_cnt);
            phase_cnt = 1;
            last_clk  = div_clk;
        end else begin
            phase_cnt++;
        end

        acc     = div_req && !m_busy && !m_ack;
        ratio_n = m_ratio;
        if (acc && idle)                  ratio_n = int'(div_val);
        else if (m_busy && (tc_now || idle)) ratio_n = m_pend;

        busy_n = m_busy;
        if (acc && !idle)                 busy_n = 1'b1;
        else if (m_busy && (tc_now || idle)) busy_n = 1'b0;

        case (m_mode)
            0:       mode_n = en ? 1 : 0;
            1:       mode_n = en ? 1 : ((m_clk && !tc_now) ? 2 : 0);
            default: mode_n = en ? 1 : (tc_now ? 0 : 2);
        endcase

        clk_n = !active ? 1'b0 : (tc_now ? !m_clk : m_clk);
        rem_n = (!active || tc_now) ? ratio_n + 1 : m_rem - 1;

        @(posedge clk);
        if (acc) m_pend = int'(div_val);
        m_ack   = acc;
        m_busy  = busy_n;
        m_ratio = ratio_n;
        m_mode  = mode_n;
        m_clk   = clk_n;
        m_rem   = rem_n;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic request(input int val);
        int n = 0;
        div_req = 1'b1;
        div_val = CNT_W'(val);
        do begin
            cyc();
            n++;
        end while (!m_ack && n < 200);
        div_req = 1'b0;
        if (!m_ack) timeout("request_ack");
    endtask

    task automatic wait_tc();
        int n = 0;
        while (!model_tc() && n < 200) begin cyc(); n++; end
        if (!model_tc()) timeout("wait_tc");
    endtask

    task automatic wait_high_start();
        int n = 0;
        while (!(m_mode == 1 && m_clk && m_rem == m_ratio + 1) && n < 200) begin cyc(); n++; end
        if (!(m_mode == 1 && m_clk)) timeout("wait_high_start");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_mode != 0 && n < 200) begin cyc(); n++; end
        if (m_mode != 0) timeout("wait_idle");
    endtask

    // Pulse reset asynchronously mid-cycle, check the forced values, release at negedge.
    task automatic do_reset();
        #2;
        clr_n = 1'b0;
        #1;
        check("rst_div_clk",  32'(div_clk),  32'd0);
        check("rst_tick",     32'(tick),     32'd0);
        check("rst_running",  32'(running),  32'd0);
        check("rst_div_ack",  32'(div_ack),  32'd0);
        check("rst_div_busy", 32'(div_busy), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        int min_len;
        clr_n   = 1'b0;
        en      = 1'b0;
        div_req = 1'b0;
        div_val = '0;
        model_reset();
        last_clk  = 1'b0;
        phase_cnt = 0;
        #1;
        check("por_div_clk",  32'(div_clk),  32'd0);
        check("por_tick",     32'(tick),     32'd0);
        check("por_running",  32'(running),  32'd0);
        check("por_div_ack",  32'(div_ack),  32'd0);
        check("por_div_busy", 32'(div_busy), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        // Reset ratio 0: divide by two, tick every running cycle.
        en = 1'b1;
        run(10);
        check("r0_phase", 32'(phases[$]), 32'd1);

        // Ratio 2 loaded while stopped, then switch to 4 while running.
        en = 1'b0;
        wait_idle();
        request(2);
        en = 1'b1;
        run(20);
        phases.delete();
        request(4);
        run(40);
        min_len = 99;
        foreach (phases[i]) if (phases[i] < min_len) min_len = phases[i];
        check("r2to4_first", 32'(phases[0]), 32'd3);
        check("r2to4_last0", 32'(phases[$]), 32'd5);
        check("r2to4_last1", 32'(phases[phases.size()-2]), 32'd5);
        check("r2to4_no_runt", 32'(min_len >= 3), 32'd1);

        // Ratio 1 requested exactly on a terminal count at ratio 3.
        en = 1'b0;
        wait_idle();
        request(3);
        en = 1'b1;
        run(16);
        wait_tc();
        div_req = 1'b1;
        div_val = CNT_W'(1);
        cyc();
        div_req = 1'b0;
        phases.delete();
        run(16);
        check("tc_req_ph0", 32'(phases[0]), 32'd4);
        check("tc_req_ph1", 32'(phases[1]), 32'd4);
        check("tc_req_ph2", 32'(phases[2]), 32'd2);
        check("tc_req_ph3", 32'(phases[3]), 32'd2);

        // Stop during a high phase at ratio 3: the high phase completes.
        en = 1'b0;
        wait_idle();
        request(3);
        en = 1'b1;
        run(12);
        wait_high_start();
        en = 1'b0;
        cyc();
        phases.delete();
        run(8);
        check("drain_phases", 32'(phases.size()), 32'd1);
        check("drain_high",   32'(phases[0]), 32'd4);
        check("drain_stop",   32'(running), 32'd0);

        // Back-to-back requests: the second is stalled until the first lands.
        request(2);
        en = 1'b1;
        run(10);
        request(7);
        request(1);
        phases.delete();
        run(30);
        check("b2b_last", 32'(phases[$]), 32'd2);

        // Largest ratio, then the same ratio requested again.
        en = 1'b0;
        wait_idle();
        request(15);
        en = 1'b1;
        run(70);
        check("r15_phase", 32'(phases[$]), 32'd16);
        request(15);
        run(40);

        // Reset while draining with a pending ratio 5.
        en = 1'b0;
        wait_idle();
        request(3);
        en = 1'b1;
        run(12);
        wait_high_start();
        en = 1'b0;
        request(5);
        cyc();
        check("pre_rst_busy", 32'(div_busy), 32'd1);
        do_reset();
        en = 1'b1;
        phases.delete();
        run(8);
        check("post_rst_phase", 32'(phases[$]), 32'd1);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if (div_req && m_ack) begin
                div_req = 1'b0;
            end else if (!div_req && $urandom_range(0, 9) == 0) begin
                div_req = 1'b1;
                div_val = CNT_W'($urandom);
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 4, SHALL be the width of the divide-ratio field and counter.
REQ-002 Parameter RESET_DIV, default 0, SHALL be the active ratio R loaded at reset (R=0 gives divide-by-two).
REQ-003 clk  input  1  SHALL be the single system clock; all state SHALL update on posedge clk.
REQ-004 clr_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the run request; 1 = produce divided clock, 0 = stop gracefully.
REQ-006 div_req  input  1  SHALL request a ratio change; held high with div_val stable until div_ack is seen.
REQ-007 div_val  input  CNT_W  SHALL carry the requested ratio R.
REQ-008 div_ack  output  1  SHALL be a registered one-cycle pulse acknowledging acceptance of div_val.
REQ-009 div_busy  output  1  SHALL be high while an accepted ratio is pending application.
REQ-010 div_clk  output  1  SHALL be the registered divided clock, period 2*(R+1) clk cycles, 50% duty.
REQ-011 tick  output  1  SHALL be a one-cycle pulse in every cycle where div_clk toggles.
REQ-012 running  output  1  SHALL be high in states RUN and DRAIN.

Function
REQ-013 States SHALL be IDLE, RUN, DRAIN.
REQ-014 IDLE: counter held 0, div_clk 0, tick 0; en=1 SHALL move to RUN next cycle.
REQ-015 RUN/DRAIN: counter SHALL increment each cycle; at counter==R (terminal count, TC) counter SHALL wrap to 0, div_clk SHALL toggle and tick SHALL be 1 in that same cycle.
REQ-016 RUN with en=0: if div_clk=0, SHALL go to IDLE next cycle; if div_clk=1, SHALL go to DRAIN.
REQ-017 DRAIN: at TC, div_clk SHALL fall to 0 and state SHALL go to IDLE; en=1 in DRAIN SHALL return to RUN without disturbing counter or div_clk.
REQ-018 High and low phases of div_clk SHALL never be shorter than R+1 cycles (no runt pulses on stop or ratio change).
REQ-019 Accept condition: div_req=1 and div_busy=0 and div_ack=0; on accept div_val SHALL be latched into pending register and div_ack SHALL pulse the next cycle.
REQ-020 In IDLE an accepted ratio SHALL become active immediately (div_busy never rises).
REQ-021 In RUN/DRAIN an accepted ratio SHALL set div_busy the next cycle and SHALL become active at the first TC strictly after acceptance; counter wraps to 0, div_busy clears the following cycle.
REQ-022 Acceptance coincident with a TC SHALL apply at the following TC, not the current one.
REQ-023 div_req while div_busy=1 SHALL be stalled (no ack) until pending is applied.
REQ-024 A requested ratio equal to the active ratio SHALL follow the same handshake and timing.
REQ-025 Counter compare SHALL be unsigned CNT_W-bit; R=2^CNT_W-1 SHALL be legal with no overflow.

Reset
REQ-026 clr_n=0 SHALL asynchronously force: state IDLE, counter 0, active ratio RESET_DIV, pending cleared, div_clk 0, tick 0, div_ack 0, div_busy 0, running 0.
REQ-027 Reset mid-operation SHALL discard any pending ratio; first div_clk edge after release SHALL follow REQ-014/015.
REQ-028 Reset deassertion SHALL take effect on the next posedge clk.

Structure
REQ-029 Package clk_ctrl_pkg SHALL hold the state enum and the CNT_W default.
REQ-030 Counter/TC/toggle logic SHALL be one sub-module clk_div_core (inputs: run, ratio; outputs: tc, div_clk); FSM and handshake stay in clk_div_ctrl.

Verification
REQ-031 Reset, en=1, R=0 -> div_clk toggles every cycle (period 2), tick constant 1 after first RUN cycle.
REQ-032 Running at R=2, request div_val=4 -> div_ack one cycle later, div_busy high until next TC, then period changes from 6 to 10 with no phase under 3 cycles.
REQ-033 Request div_val=1 accepted on a TC cycle at R=3 -> old ratio holds for one more full phase (4 cycles), then phase 2.
REQ-034 R=3, drop en while div_clk=1 -> DRAIN, div_clk falls at TC after full 4-cycle high phase, IDLE, running 0.
REQ-035 Second div_req while div_busy=1 -> no div_ack until first ratio applied; then ack and second ratio applied at following TC.
REQ-036 clr_n pulsed low during DRAIN with pending ratio 5 -> all outputs 0 immediately, ratio RESET_DIV after release.
